interface_dac_tx: RTL and testbench
===================================

INTERFACE_DAC_TX -- requirements
Module: interface_dac_tx

Interface
REQ-001 The module SHALL have parameter N, default 25, the width of the filter output word Yk.
REQ-002 The module SHALL have parameter F, default 16, the number of fractional bits of Yk (signed two's complement).
REQ-003 The module SHALL have parameter DIV, default 2, the number of Clk cycles per SCLK half-period (legal values 1 to 255).
REQ-004 The module SHALL have parameter GAP, default 2, the minimum number of Clk cycles SYNC_n stays high between frames (legal values 1 to 255).
REQ-005 Clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Yk  input  N  signed filter output sample.
REQ-008 Bandera_Listo  input  1  one-cycle strobe: Yk is valid in this cycle.
REQ-009 SCLK  output  1  serial clock to the DAC.
REQ-010 SYNC_n  output  1  active-low frame select to the DAC.
REQ-011 DIN  output  1  serial data to the DAC, MSB first.
REQ-012 Ocupado  output  1  high while a frame or inter-frame gap is in progress.
REQ-013 Bandera_Enviado  output  1  one-cycle pulse at frame completion.
REQ-014 Sobrecarga  output  1  one-cycle pulse when a pending sample is overwritten.

Function
REQ-015 Conversion SHALL saturate Yk to the range [-1.0, +1.0 - 2^-F].
- Yk >= 2^F SHALL give code 0xFFF.
- Yk < -2^F SHALL give code 0x000.
- Otherwise code SHALL be {~Yk[F], Yk[F-1:F-11]} (12-bit offset binary).
REQ-016 The frame SHALL be 16 bits: 4'b0000 (normal-operation control bits) followed by the 12-bit code, MSB first.
REQ-017 The FSM SHALL have states IDLE, SHIFT, GAP.
- IDLE -> SHIFT when a sample is captured or pending.
- SHIFT -> GAP after the 16th SCLK falling edge plus DIV cycles.
- GAP -> IDLE after GAP cycles.
- GAP -> SHIFT directly when a sample is pending and the gap has elapsed.
REQ-018 When Bandera_Listo is high at edge k in IDLE, the code SHALL be computed from Yk and latched at edge k.
- SYNC_n SHALL go low after edge k.
- SCLK SHALL be high and DIN SHALL be frame bit 15 after edge k.
- Ocupado SHALL be high after edge k.
REQ-019 In SHIFT, SCLK SHALL toggle every DIV cycles.
- DIN SHALL change only coincident with SCLK rising edges (the frame start counts as a rising edge).
- The DAC samples on falling edges; 16 falling edges SHALL occur per frame.
REQ-020 After the 16th falling edge, SCLK SHALL stay low DIV cycles, then SYNC_n and SCLK SHALL both go high at one edge.
- Bandera_Enviado SHALL pulse in the following cycle.
- SYNC_n SHALL be low for exactly 32*DIV cycles per frame.
REQ-021 If Bandera_Listo arrives while Ocupado is high, the code SHALL be stored in a one-deep pending register.
- A second arrival before that register drains SHALL overwrite it with the newer code and pulse Sobrecarga for one cycle.
REQ-022 A pending sample SHALL start its frame on the first cycle after GAP completes, without returning to IDLE.
- Ocupado SHALL remain high across that transition.
REQ-023 Bandera_Listo coincident with the GAP->IDLE transition edge SHALL be captured and start the next frame one cycle later, with no sample lost.
REQ-024 Yk SHALL be ignored when Bandera_Listo is low; changes to Yk during a frame SHALL NOT alter the transmitted bits.

Reset
REQ-025 While Reset is high, the outputs SHALL hold these values:
- SCLK=1, SYNC_n=1, DIN=0, Ocupado=0, Bandera_Enviado=0, Sobrecarga=0.
- FSM=IDLE, pending register empty, all counters zero.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately (SYNC_n high asynchronously) with no Bandera_Enviado pulse.
REQ-027 After Reset deasserts, the first Bandera_Listo SHALL be accepted on the next rising edge.

Verification (N=25, F=16, DIV=2, GAP=2)
REQ-028 Yk=0, one strobe -> DIN frame 0x0800 sampled on SCLK falls; SYNC_n low 64 cycles; one Bandera_Enviado.
REQ-029 Yk=0x008000 (+0.5) -> frame 0x0C00; Yk=0x1FF0000 (-1.0) -> frame 0x0000.
REQ-030 Yk=0x0030000 (+3.0) -> frame 0x0FFF; Yk=0x1FC0000 (-4.0) -> frame 0x0000 (saturation).
REQ-031 Strobes A, B, C, with B and C both arriving during frame A -> frames A then C, one Sobrecarga pulse, SYNC_n high exactly 2 cycles between frames.
REQ-032 Reset pulse at cycle 20 of a frame -> SYNC_n=1 and SCLK=1 immediately, no Bandera_Enviado; a new strobe afterward yields a complete correct frame.

Source files
------------

// File: rtl/interface_dac_tx.sv
// Serialises saturated filter samples into 16-bit frames (4 control bits + 12-bit code) for an SPI DAC.
// Latency: frame starts on the strobe edge when idle; SYNC_n low 32*DIV cycles, then GAP cycles high.
// Backpressure: none upstream; one-deep pending slot, a newer sample overwrites it and pulses Sobrecarga.
module interface_dac_tx #(
    parameter int N   = 25,
    parameter int F   = 16,
    parameter int DIV = 2,
    parameter int GAP = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic signed [N-1:0] Yk,
    input  logic                Bandera_Listo,
    output logic                SCLK,
    output logic                SYNC_n,
    output logic                DIN,
    output logic                Ocupado,
    output logic                Bandera_Enviado,
    output logic                Sobrecarga
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_cnt_nxt;     // Clk cycles within the current SCLK half-period
    logic [4:0]  half_cnt, half_cnt_nxt;   // SCLK half-periods elapsed in the frame (odd = SCLK low)
    logic [7:0]  gap_cnt, gap_cnt_nxt;
    logic [14:0] shreg, shreg_nxt;         // frame bits still to be shifted out, next bit at [14]
    logic        pend_vld, pend_vld_nxt;
    logic [11:0] pend_code, pend_code_nxt;
    logic        sclk_nxt, sync_nxt, din_nxt, enviado_nxt, sobrecarga_nxt;
    logic [11:0] code;
    logic        start;
    logic [15:0] start_frame;
    logic        unused_lsbs;

    // Fraction bits below the 12-bit DAC resolution are dropped on purpose
    assign unused_lsbs = ^Yk[F-12:0];

    assign Ocupado = (state != S_IDLE);

    // Saturate to [-1, 1) and keep sign plus 11 fraction bits as offset binary
    always_comb begin
        code = {~Yk[F], Yk[F-1:F-11]};
        if (!((&Yk[N-1:F]) || !(|Yk[N-1:F]))) begin
            code = Yk[N-1] ? 12'h000 : 12'hFFF;
        end
    end

    // Next-state and output logic: frame sequencing, pending slot, SCLK/DIN generation
    always_comb begin
        state_nxt      = state;
        div_cnt_nxt    = div_cnt;
        half_cnt_nxt   = half_cnt;
        gap_cnt_nxt    = gap_cnt;
        shreg_nxt      = shreg;
        pend_vld_nxt   = pend_vld;
        pend_code_nxt  = pend_code;
        sclk_nxt       = SCLK;
        sync_nxt       = SYNC_n;
        din_nxt        = DIN;
        enviado_nxt    = 1'b0;
        sobrecarga_nxt = 1'b0;
        start          = 1'b0;
        start_frame    = 16'h0000;

        case (state)
            S_IDLE: begin
                if (Bandera_Listo) begin
                    // Fresh sample wins over a stale pending one
                    start          = 1'b1;
                    start_frame    = {4'b0000, code};
                    sobrecarga_nxt = pend_vld;
                    pend_vld_nxt   = 1'b0;
                end else if (pend_vld) begin
                    start        = 1'b1;
                    start_frame  = {4'b0000, pend_code};
                    pend_vld_nxt = 1'b0;
                end
            end

            S_SHIFT: begin
                if (Bandera_Listo) begin
                    pend_code_nxt  = code;
                    pend_vld_nxt   = 1'b1;
                    sobrecarga_nxt = pend_vld;
                end
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = 8'd0;
                    if (half_cnt == 5'd31) begin
                        // Low hold after the 16th falling edge is over: close the frame
                        state_nxt   = S_GAP;
                        sclk_nxt    = 1'b1;
                        sync_nxt    = 1'b1;
                        din_nxt     = 1'b0;
                        enviado_nxt = 1'b1;
                        gap_cnt_nxt = 8'd0;
                    end else begin
                        half_cnt_nxt = half_cnt + 5'd1;
                        sclk_nxt     = ~SCLK;
                        if (half_cnt[0]) begin
                            // SCLK rising: present the next bit
                            din_nxt   = shreg[14];
                            shreg_nxt = {shreg[13:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 8'd1;
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (pend_vld) begin
                        start        = 1'b1;
                        start_frame  = {4'b0000, pend_code};
                        pend_vld_nxt = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                    // The slot is draining or empty here, so a new arrival is never an overwrite
                    if (Bandera_Listo) begin
                        pend_code_nxt = code;
                        pend_vld_nxt  = 1'b1;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                    if (Bandera_Listo) begin
                        pend_code_nxt  = code;
                        pend_vld_nxt   = 1'b1;
                        sobrecarga_nxt = pend_vld;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        if (start) begin
            state_nxt    = S_SHIFT;
            shreg_nxt    = start_frame[14:0];
            din_nxt      = start_frame[15];
            sclk_nxt     = 1'b1;
            sync_nxt     = 1'b0;
            div_cnt_nxt  = 8'd0;
            half_cnt_nxt = 5'd0;
        end
    end

    // State and output registers; reset aborts any frame with SYNC_n and SCLK high
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= S_IDLE;
            div_cnt         <= 8'd0;
            half_cnt        <= 5'd0;
            gap_cnt         <= 8'd0;
            shreg           <= 15'd0;
            pend_vld        <= 1'b0;
            pend_code       <= 12'd0;
            SCLK            <= 1'b1;
            SYNC_n          <= 1'b1;
            DIN             <= 1'b0;
            Bandera_Enviado <= 1'b0;
            Sobrecarga      <= 1'b0;
        end else begin
            state           <= state_nxt;
            div_cnt         <= div_cnt_nxt;
            half_cnt        <= half_cnt_nxt;
            gap_cnt         <= gap_cnt_nxt;
            shreg           <= shreg_nxt;
            pend_vld        <= pend_vld_nxt;
            pend_code       <= pend_code_nxt;
            SCLK            <= sclk_nxt;
            SYNC_n          <= sync_nxt;
            DIN             <= din_nxt;
            Bandera_Enviado <= enviado_nxt;
            Sobrecarga      <= sobrecarga_nxt;
        end
    end

endmodule

// File: tb/tb_interface_dac_tx.sv
// Bench for interface_dac_tx: directed and random strobes against a frame-level timing model.
// Latency: expected frame start edge is predicted per strobe and compared at frame end.
// Backpressure: model tracks busy window and one-deep pending slot to predict overwrites.
module tb_interface_dac_tx;

    localparam int N         = 25;
    localparam int F         = 16;
    localparam int DIV       = 2;
    localparam int GAP       = 2;
    localparam int FRAME_CYC = 32 * DIV;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] Yk = '0;
    logic         Bandera_Listo = 1'b0;
    logic         SCLK, SYNC_n, DIN, Ocupado, Bandera_Enviado, Sobrecarga;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [15:0] frame;
        int          start;
    } exp_t;

    exp_t        exp_q[$];
    int          m_free_at = -1000;   // edge at which the transmitter can start a new frame
    bit          m_pend_vld = 1'b0;
    logic [15:0] m_pend_frame = 16'h0;
    int          m_pushed = 0;
    int          m_sobre = 0;
    int          env_cnt = 0;
    int          sob_cnt = 0;

    interface_dac_tx #(.N(N), .F(F), .DIV(DIV), .GAP(GAP)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Yk              (Yk),
        .Bandera_Listo   (Bandera_Listo),
        .SCLK            (SCLK),
        .SYNC_n          (SYNC_n),
        .DIN             (DIN),
        .Ocupado         (Ocupado),
        .Bandera_Enviado (Bandera_Enviado),
        .Sobrecarga      (Sobrecarga)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected frame from the numeric value: clamp to [-1, 1), quantise to 2^-11 steps, offset by 2048
    function automatic logic [15:0] ref_frame(input logic [N-1:0] y);
        logic signed [N-1:0] ys;
        int v, q;
        int full = 1 << F;
        int step = 1 << (F - 11);
        ys = y;
        v  = ys;
        if (v >= full) return 16'h0FFF;
        if (v < -full) return 16'h0000;
        q = v / step;
        if (v < 0 && (v % step) != 0) q = q - 1;
        return 16'(q + 2048);
    endfunction

    task automatic m_push(input logic [15:0] fr, input int st);
        exp_t e;
        e.frame = fr;
        e.start = st;
        exp_q.push_back(e);
        m_pushed++;
    endtask

    // A pending sample begins transmitting exactly when the transmitter frees up
    task automatic m_drain(input int now);
        if (m_pend_vld && now >= m_free_at) begin
            m_push(m_pend_frame, m_free_at);
            m_free_at  = m_free_at + FRAME_CYC + GAP;
            m_pend_vld = 1'b0;
        end
    endtask

    task automatic m_strobe(input int s, input logic [15:0] fr);
        int st;
        m_drain(s);
        if (s < m_free_at) begin
            if (m_pend_vld) m_sobre++;
            m_pend_vld   = 1'b1;
            m_pend_frame = fr;
        end else begin
            st = (s == m_free_at) ? s + 1 : s;
            m_push(fr, st);
            m_free_at = st + FRAME_CYC + GAP;
        end
    endtask

    task automatic m_flush();
        m_pushed   = m_pushed - exp_q.size();
        exp_q.delete();
        m_pend_vld = 1'b0;
        m_free_at  = -1000;
    endtask

    // Called at a falling clock edge; strobe is sampled by the next rising edge
    task automatic strobe(input logic [N-1:0] y);
        Yk            = y;
        Bandera_Listo = 1'b1;
        m_strobe(edge_cnt + 1, ref_frame(y));
        @(negedge Clk);
        Bandera_Listo = 1'b0;
        Yk            = N'($urandom);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((m_pend_vld || exp_q.size() != 0 || edge_cnt < m_free_at + 2) && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        chk("quiet_timeout", int'(n < 4000), 1);
    endtask

    task automatic wait_free_edge();
        while (edge_cnt + 1 < m_free_at) @(negedge Clk);
    endtask

    // Monitor: rebuild each frame from DIN at SCLK falls and score it against the queue
    bit          in_frame = 1'b0;
    bit          prev_sclk = 1'b1;
    bit          prev_sync = 1'b1;
    bit          f_ocup_ok;
    int          f_start, f_nfall;
    logic [15:0] f_bits;
    exp_t        f_exp;

    always @(negedge Clk) begin
        if (Reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && prev_sync && !SYNC_n) begin
                in_frame  = 1'b1;
                f_start   = edge_cnt;
                f_bits    = 16'h0;
                f_nfall   = 0;
                f_ocup_ok = Ocupado;
            end else if (in_frame) begin
                if (!SYNC_n) begin
                    if (!Ocupado) f_ocup_ok = 1'b0;
                    if (prev_sclk && !SCLK) begin
                        f_bits  = {f_bits[14:0], DIN};
                        f_nfall = f_nfall + 1;
                    end
                end else begin
                    in_frame = 1'b0;
                    m_drain(edge_cnt);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: actual=%04h required=none", f_bits);
                    end else begin
                        f_exp = exp_q.pop_front();
                        chk("frame_bits", f_bits, f_exp.frame);
                        chk("frame_start_edge", f_start, f_exp.start);
                    end
                    chk("sync_low_cycles", edge_cnt - f_start, FRAME_CYC);
                    chk("sclk_falls", f_nfall, 16);
                    chk("sclk_high_at_end", SCLK, 1);
                    chk("enviado_at_end", Bandera_Enviado, 1);
                    chk("ocupado_in_frame", f_ocup_ok, 1);
                end
            end
            if (Bandera_Enviado) env_cnt++;
            if (Sobrecarga) sob_cnt++;
        end
        prev_sclk = SCLK;
        prev_sync = SYNC_n;
    end

    logic [N-1:0] dir_y [8] = '{25'h0000000, 25'h0008000, 25'h1FF0000, 25'h0030000,
                                25'h1FC0000, 25'h000FFFF, 25'h0010000, 25'h1FFFFFF};

    initial begin
        logic [N-1:0] y;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_sclk", SCLK, 1);
        chk("rst_sync_n", SYNC_n, 1);
        chk("rst_din", DIN, 0);
        chk("rst_ocupado", Ocupado, 0);
        chk("rst_enviado", Bandera_Enviado, 0);
        chk("rst_sobrecarga", Sobrecarga, 0);

        // First strobe on the very first edge after reset release
        Reset = 1'b0;
        foreach (dir_y[i]) begin
            strobe(dir_y[i]);
            wait_quiet();
        end

        // A, then B and C during A: A then C, one overwrite, minimal gap
        strobe(25'h0004000);
        repeat (8) @(negedge Clk);
        strobe(25'h1FF8000);
        repeat (8) @(negedge Clk);
        strobe(25'h000C000);
        wait_quiet();
        chk("abc_sobrecarga", sob_cnt, m_sobre);

        // Strobe on the gap-end edge with nothing pending
        strobe(25'h0002000);
        wait_free_edge();
        strobe(25'h1FFA000);
        wait_quiet();

        // Strobe on the gap-end edge while a pending sample drains
        strobe(25'h0006000);
        repeat (5) @(negedge Clk);
        strobe(25'h1FE0000);
        wait_free_edge();
        strobe(25'h000A000);
        wait_quiet();

        // Reset mid-frame, then a clean frame
        strobe(25'h0007000);
        repeat (18) @(negedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        m_flush();
        #1;
        chk("abort_sync_n", SYNC_n, 1);
        chk("abort_sclk", SCLK, 1);
        chk("abort_ocupado", Ocupado, 0);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        strobe(25'h1FF4000);
        wait_quiet();

        // Random traffic, some strobes collide with busy frames
        repeat (40) begin
            if ($urandom_range(0, 1) == 1) y = N'($urandom_range(0, 262143) - 131072);
            else y = N'($urandom);
            strobe(y);
            repeat ($urandom_range(2, 90)) @(negedge Clk);
        end
        wait_quiet();

        chk("enviado_count", env_cnt, m_pushed);
        chk("sobrecarga_count", sob_cnt, m_sobre);
        chk("final_ocupado", Ocupado, 0);
        chk("final_sync_n", SYNC_n, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: actual=running required=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
